// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX->MEM bus, extracts and extends
// load data, and drives the writeback bus plus a same-cycle forwarding bus.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70,
  parameter int STALL_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_id_fwd
);

  localparam logic STOP = 1'b1;

  logic [EX_TO_MEM_WD-1:0] bus_d, bus_q;
  logic [31:0]             rdata_hold_d, rdata_hold_q;
  logic                    hold_vld_d, hold_vld_q;

  logic [31:0] mem_pc;
  logic [2:0]  mem_op;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic        is_load;

  assign mem_pc       = bus_q[78:47];
  assign mem_op       = bus_q[46:44];
  assign data_ram_en  = bus_q[43];
  assign data_ram_wen = bus_q[42:39];
  assign sel_rf_res   = bus_q[38];
  assign rf_we        = bus_q[37];
  assign rf_waddr     = bus_q[36:32];
  assign ex_result    = bus_q[31:0];
  assign is_load      = data_ram_en && (data_ram_wen == 4'b0000);

  // Capture read data on the first held edge so a long MEM stall keeps the
  // load result stable even after the SRAM output moves on.
  always_comb begin
    bus_d        = bus_q;
    rdata_hold_d = rdata_hold_q;
    hold_vld_d   = hold_vld_q;
    if (stall[3] == STOP && stall[4] != STOP) begin
      bus_d      = '0;
      hold_vld_d = 1'b0;
    end else if (stall[3] != STOP) begin
      bus_d      = ex_to_mem_bus;
      hold_vld_d = 1'b0;
    end else if (!hold_vld_q && is_load) begin
      rdata_hold_d = data_sram_rdata;
      hold_vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q        <= '0;
      rdata_hold_q <= '0;
      hold_vld_q   <= 1'b0;
    end else begin
      bus_q        <= bus_d;
      rdata_hold_q <= rdata_hold_d;
      hold_vld_q   <= hold_vld_d;
    end
  end

  logic [31:0] rdata;
  logic [1:0]  off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;

  assign rdata    = hold_vld_q ? rdata_hold_q : data_sram_rdata;
  assign off      = ex_result[1:0];
  assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  always_comb begin
    load_data = rdata;
    case (mem_op)
      3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  load_data = {24'b0, byte_sel};
      3'b011:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {16'b0, half_sel};
      default: load_data = rdata;
    endcase
  end

  assign rf_wdata      = sel_rf_res ? load_data : ex_result;
  assign mem_to_wb_bus = {mem_pc, rf_we, rf_waddr, rf_wdata};
  assign mem_to_id_fwd = {rf_we, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [78:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_id_fwd;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_id_fwd   (mem_to_id_fwd)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [69:0] wb;
    logic        hv;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [5:0] S_RUN  = 6'b000000;
  localparam logic [5:0] S_HOLD = 6'b011000;
  localparam logic [5:0] S_BUB  = 6'b001000;

  function automatic logic [78:0] mk_bus(input logic [31:0] pc, input logic [2:0] op,
                                         input logic en, input logic [3:0] wen,
                                         input logic sel, input logic we,
                                         input logic [4:0] wa, input logic [31:0] res);
    return {pc, op, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [78:0] mk_ld(input logic [31:0] pc, input logic [2:0] op,
                                        input logic [4:0] wa, input logic [31:0] addr);
    return mk_bus(pc, op, 1'b1, 4'h0, 1'b1, 1'b1, wa, addr);
  endfunction

  function automatic logic [78:0] mk_alu(input logic [31:0] pc, input logic [4:0] wa,
                                         input logic [31:0] res);
    return mk_bus(pc, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, wa, res);
  endfunction

  function automatic logic [69:0] mk_wb(input logic [31:0] pc, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    return {pc, we, wa, wd};
  endfunction

  // One cycle: after the edge, drive inputs and (optionally) queue the value
  // the outputs must show during this cycle.
  task automatic cyc(input logic r, input logic [5:0] s, input logic [78:0] b,
                     input logic [31:0] rd, input logic chk, input string nm,
                     input logic [69:0] ewb, input logic ehv);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    stall           = s;
    ex_to_mem_bus   = b;
    data_sram_rdata = rd;
    if (chk) begin
      e.name = nm;
      e.wb   = ewb;
      e.hv   = ehv;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (mem_to_wb_bus !== e.wb) begin
        errors++;
        $display("FAIL %s wb_bus: got %h want %h", e.name, mem_to_wb_bus, e.wb);
      end
      checks++;
      if (mem_to_id_fwd !== e.wb[37:0]) begin
        errors++;
        $display("FAIL %s fwd: got %h want %h", e.name, mem_to_id_fwd, e.wb[37:0]);
      end
      checks++;
      if (dut.hold_vld_q !== e.hv) begin
        errors++;
        $display("FAIL %s hold_vld: got %b want %b", e.name, dut.hold_vld_q, e.hv);
      end
    end
  end

  logic [95:0] r96;
  logic [78:0] bus_n;
  logic [78:0] bus_m;
  logic [78:0] bus_k;
  localparam logic [31:0] RD = 32'h80FF7F01;
  localparam logic [69:0] Z  = 70'd0;

  initial begin
    rst = 1'b1;
    stall = S_RUN;
    ex_to_mem_bus = '0;
    data_sram_rdata = '0;
    bus_n = mk_alu(32'h204, 5'd17, 32'h0BADF00D);
    bus_m = mk_alu(32'h300, 5'd7, 32'hDEADBEEF);
    bus_k = mk_alu(32'h304, 5'd8, 32'h00000005);

    r96 = {$urandom(), $urandom(), $urandom()};
    cyc(1, S_RUN, r96[78:0], $urandom(), 0, "", Z, 0);
    r96 = {$urandom(), $urandom(), $urandom()};
    cyc(1, S_RUN, r96[78:0], $urandom(), 1, "reset", Z, 0);
    cyc(0, S_RUN, mk_alu(32'h100, 5'd5, 32'h12345678), $urandom(), 1, "reset_release", Z, 0);

    cyc(0, S_RUN, mk_ld(32'h104, 3'b001, 5'd6, 32'h1002), RD, 1, "alu",
        mk_wb(32'h100, 1, 5'd5, 32'h12345678), 0);
    cyc(0, S_RUN, mk_ld(32'h108, 3'b010, 5'd7, 32'h1002), RD, 1, "lb",
        mk_wb(32'h104, 1, 5'd6, 32'hFFFFFFFF), 0);
    cyc(0, S_RUN, mk_ld(32'h10C, 3'b011, 5'd8, 32'h1002), RD, 1, "lbu",
        mk_wb(32'h108, 1, 5'd7, 32'h000000FF), 0);
    cyc(0, S_RUN, mk_ld(32'h110, 3'b100, 5'd9, 32'h1002), RD, 1, "lh",
        mk_wb(32'h10C, 1, 5'd8, 32'hFFFF80FF), 0);
    cyc(0, S_RUN, mk_ld(32'h114, 3'b000, 5'd10, 32'h1002), RD, 1, "lhu",
        mk_wb(32'h110, 1, 5'd9, 32'h000080FF), 0);
    cyc(0, S_RUN, mk_ld(32'h118, 3'b001, 5'd11, 32'h1001), RD, 1, "lw",
        mk_wb(32'h114, 1, 5'd10, 32'h80FF7F01), 0);
    cyc(0, S_RUN, mk_ld(32'h11C, 3'b011, 5'd12, 32'h1000), RD, 1, "lb_off1",
        mk_wb(32'h118, 1, 5'd11, 32'h0000007F), 0);
    cyc(0, S_RUN, mk_ld(32'h120, 3'b101, 5'd13, 32'h1003), RD, 1, "lh_off0",
        mk_wb(32'h11C, 1, 5'd12, 32'h00007F01), 0);
    cyc(0, S_RUN, mk_bus(32'h124, 3'b000, 1, 4'hF, 0, 0, 5'd14, 32'h1008), RD, 1, "op101_lw",
        mk_wb(32'h120, 1, 5'd13, 32'h80FF7F01), 0);
    cyc(0, S_RUN, mk_ld(32'h128, 3'b011, 5'd15, 32'h1003), RD, 1, "store",
        mk_wb(32'h124, 0, 5'd14, 32'h00001008), 0);
    cyc(0, S_RUN, mk_ld(32'h200, 3'b000, 5'd16, 32'h2000), RD, 1, "lh_off3",
        mk_wb(32'h128, 1, 5'd15, 32'hFFFF80FF), 0);

    cyc(0, S_HOLD, bus_n, 32'hAAAA5555, 1, "stall0", mk_wb(32'h200, 1, 5'd16, 32'hAAAA5555), 0);
    cyc(0, S_HOLD, bus_n, 32'h0, 1, "stall1", mk_wb(32'h200, 1, 5'd16, 32'hAAAA5555), 1);
    cyc(0, S_HOLD, bus_n, 32'h0, 1, "stall2", mk_wb(32'h200, 1, 5'd16, 32'hAAAA5555), 1);
    cyc(0, S_RUN,  bus_n, 32'h0, 1, "stall3", mk_wb(32'h200, 1, 5'd16, 32'hAAAA5555), 1);
    cyc(0, S_RUN,  bus_m, 32'h0, 1, "release", mk_wb(32'h204, 1, 5'd17, 32'h0BADF00D), 0);

    cyc(0, S_BUB, bus_k, 32'h0, 1, "pre_bubble", mk_wb(32'h300, 1, 5'd7, 32'hDEADBEEF), 0);
    cyc(0, S_RUN, bus_k, 32'h0, 1, "bubble", Z, 0);
    cyc(0, S_RUN, mk_ld(32'h400, 3'b100, 5'd10, 32'h4000), 32'h0, 1, "post_bubble",
        mk_wb(32'h304, 1, 5'd8, 32'h00000005), 0);

    cyc(0, S_HOLD, bus_k, 32'h1234ABCD, 1, "rst_ld", mk_wb(32'h400, 1, 5'd10, 32'h0000ABCD), 0);
    cyc(0, S_HOLD, bus_k, 32'h0, 1, "rst_hold", mk_wb(32'h400, 1, 5'd10, 32'h0000ABCD), 1);
    cyc(1, S_HOLD, bus_k, 32'h0, 1, "rst_pre", mk_wb(32'h400, 1, 5'd10, 32'h0000ABCD), 1);
    cyc(0, S_HOLD, bus_k, 32'h0, 1, "rst_mid", Z, 0);
    cyc(0, S_RUN,  '0,    32'h0, 1, "rst_after", Z, 0);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
